dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-cycle, word-addressed data memory between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1). Each cycle it picks at most one requester using round-robin with a bounded lock. It drives the memory's read/write controls, then registers the memory's combinational read data into a per-port response one cycle later. It sits directly between the requesters and the data memory instance.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of the single-cycle data memory.
// Grants are combinational; load data is registered into the granted port one cycle later.
module dmem_arbiter #(
    parameter int MAX_LOCK = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    port_t            last;
    port_t            lock_port;
    logic             lock_valid;
    logic [CNT_W-1:0] lock_cnt;

    logic [1:0] gnt;
    logic       owner_req;
    logic       forced;
    logic       xfer;
    port_t      sel_port;
    logic       sel_we;
    logic       sel_lock;

    // Grant is forced low while reset is high so nothing can reach the memory.
    always_comb begin
        owner_req = (lock_port == PORT1) ? p1_req : p0_req;
        forced    = lock_valid && owner_req && (lock_cnt < CNT_MAX);
        gnt       = 2'b00;
        if (!rst) begin
            if (forced) begin
                gnt = (lock_port == PORT1) ? 2'b10 : 2'b01;
            end else if (p0_req && p1_req) begin
                gnt = (last == PORT0) ? 2'b10 : 2'b01;
            end else begin
                gnt = {p1_req, p0_req};
            end
        end
    end

    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];
    assign xfer   = |gnt;

    always_comb begin
        sel_port  = gnt[1] ? PORT1 : PORT0;
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[1]) begin
            sel_we    = p1_we;
            sel_lock  = p1_lock;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (gnt[0]) begin
            sel_we    = p0_we;
            sel_lock  = p0_lock;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end
    end

    assign mem_read  = xfer & ~sel_we;
    assign mem_write = xfer &  sel_we;

    // The lock count saturates so an owner that keeps winning uncontested stays bounded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last       <= PORT1;
            lock_valid <= 1'b0;
            lock_port  <= PORT0;
            lock_cnt   <= '0;
        end else if (xfer) begin
            last <= sel_port;
            if (sel_lock) begin
                lock_valid <= 1'b1;
                lock_port  <= sel_port;
                if (lock_valid && (lock_port == sel_port)) begin
                    lock_cnt <= (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
                end else begin
                    lock_cnt <= CNT_W'(1);
                end
            end else begin
                lock_valid <= 1'b0;
                lock_cnt   <= '0;
            end
        end else if (lock_valid && !owner_req) begin
            lock_valid <= 1'b0;
            lock_cnt   <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= mem_read & gnt[0];
            p1_rvalid <= mem_read & gnt[1];
            if (mem_read && gnt[0]) begin
                p0_rdata <= mem_rdata;
            end
            if (mem_read && gnt[1]) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference arbiter/memory model predicts grants and
// load data, and a negedge monitor matches every rvalid against the queued expectations.
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 4;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory fixture: combinational read, write at the rising edge.
    logic [31:0] fmem [256];
    assign mem_rdata = fmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) fmem[mem_addr[9:2]] = mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                     name, cyc, actual, expected);
        end
    endtask

    // Reference model state: who moved last, who owns the lock, and its streak length.
    logic [31:0] mmem [256];
    int   m_last  = 1;
    int   m_owner = -1;
    int   m_streak = 0;
    exp_t sb [2][$];

    function automatic req_t mk(input logic r, input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic l);
        req_t s;
        s.req = r; s.we = we; s.addr = a; s.wdata = d; s.lock = l;
        return s;
    endfunction

    function automatic int model_grant(input req_t s0, input req_t s1, input logic r);
        logic owner_wants;
        if (r) return -1;
        owner_wants = (m_owner == 0) ? s0.req : (m_owner == 1) ? s1.req : 1'b0;
        if (m_owner >= 0 && owner_wants && m_streak < MAX_LOCK) return m_owner;
        if (s0.req && s1.req) return 1 - m_last;
        if (s0.req) return 0;
        if (s1.req) return 1;
        return -1;
    endfunction

    task automatic apply_stimulus(input req_t s0, input req_t s1, input logic rst_v,
                                  output int g_exp, output int g_seen);
        req_t  sg;
        logic  owner_wants;
        #1;
        rst = rst_v;
        p0_req = s0.req; p0_we = s0.we; p0_addr = s0.addr; p0_wdata = s0.wdata; p0_lock = s0.lock;
        p1_req = s1.req; p1_we = s1.we; p1_addr = s1.addr; p1_wdata = s1.wdata; p1_lock = s1.lock;
        #1;
        g_exp  = model_grant(s0, s1, rst_v);
        g_seen = p1_gnt ? 1 : (p0_gnt ? 0 : -1);
        sg     = (g_exp == 1) ? s1 : s0;
        check_output("p0_gnt", p0_gnt, (g_exp == 0) ? 1 : 0);
        check_output("p1_gnt", p1_gnt, (g_exp == 1) ? 1 : 0);
        check_output("mem_read",  mem_read,  (g_exp >= 0 && !sg.we) ? 1 : 0);
        check_output("mem_write", mem_write, (g_exp >= 0 &&  sg.we) ? 1 : 0);
        check_output("mem_addr",  mem_addr,  (g_exp >= 0) ? sg.addr : 32'h0);
        check_output("mem_wdata", mem_wdata, (g_exp >= 0) ? sg.wdata : 32'h0);
        owner_wants = (m_owner == 0) ? s0.req : (m_owner == 1) ? s1.req : 1'b0;
        if (rst_v) begin
            m_last = 1; m_owner = -1; m_streak = 0;
        end else if (g_exp >= 0) begin
            if (sg.we) mmem[sg.addr[9:2]] = sg.wdata;
            else sb[g_exp].push_back('{due: cyc + 1, data: mmem[sg.addr[9:2]]});
            if (sg.lock) begin
                m_streak = (m_owner == g_exp) ? ((m_streak < MAX_LOCK) ? m_streak + 1 : MAX_LOCK) : 1;
                m_owner  = g_exp;
            end else begin
                m_owner = -1; m_streak = 0;
            end
            m_last = g_exp;
        end else if (m_owner >= 0 && !owner_wants) begin
            m_owner = -1; m_streak = 0;
        end
        @(posedge clk);
    endtask

    // Monitor: pops an expectation exactly on the cycle its rvalid is due.
    logic        rv [2];
    logic [31:0] rd [2];
    logic [31:0] held [2] = '{32'h0, 32'h0};
    assign rv[0] = p0_rvalid;
    assign rv[1] = p1_rvalid;
    assign rd[0] = p0_rdata;
    assign rd[1] = p1_rdata;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                check_output($sformatf("rst_rvalid%0d", p), {31'h0, rv[p]}, 32'h0);
                check_output($sformatf("rst_rdata%0d", p), rd[p], 32'h0);
                sb[p].delete();
                held[p] = 32'h0;
            end else if (sb[p].size() > 0 && sb[p][0].due == cyc) begin
                check_output($sformatf("rvalid%0d", p), {31'h0, rv[p]}, 32'h1);
                check_output($sformatf("rdata%0d", p), rd[p], sb[p][0].data);
                held[p] = sb[p][0].data;
                void'(sb[p].pop_front());
            end else begin
                check_output($sformatf("idle_rvalid%0d", p), {31'h0, rv[p]}, 32'h0);
                check_output($sformatf("hold_rdata%0d", p), rd[p], held[p]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic req_t rand_req();
        logic [31:0] a;
        a = (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'hFFFF_FC03);
        return mk(1'b1, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) < 6));
    endfunction

    req_t idle;
    req_t pend [2];
    int   ge, gs;
    int   lock_seq [5] = '{1, 1, 1, 1, 0};

    initial begin
        idle = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            fmem[i] = 32'hA5A5_0000 + 32'(i);
            mmem[i] = 32'hA5A5_0000 + 32'(i);
        end
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_lock = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_lock = 0;
        repeat (2) @(posedge clk);

        // Store then load on port 0.
        apply_stimulus(mk(1, 1, 32'h10, 32'hDEADBEEF, 0), idle, 1'b0, ge, gs);
        check_output("store_gnt_p0", gs, 0);
        apply_stimulus(mk(1, 0, 32'h10, 32'h0, 0), idle, 1'b0, ge, gs);
        check_output("load_gnt_p0", gs, 0);

        // Fresh reset, then both ports load continuously: strict alternation from p0.
        apply_stimulus(idle, idle, 1'b1, ge, gs);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(mk(1, 0, 32'h10, 0, 0), mk(1, 0, 32'h40, 0, 0), 1'b0, ge, gs);
            check_output($sformatf("alternate_%0d", i), gs, i % 2);
        end

        // Port 1 holds a lock while port 0 waits: four p1 grants, then p0.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus((i == 0) ? idle : mk(1, 0, 32'h44, 0, 0),
                           mk(1, 0, 32'h48, 0, 1), 1'b0, ge, gs);
            check_output($sformatf("lock_seq_%0d", i), gs, lock_seq[i]);
        end
        apply_stimulus(idle, idle, 1'b0, ge, gs);

        // Read-after-write across ports through an aliased address.
        apply_stimulus(mk(1, 1, 32'h20, 32'h12345678, 0), idle, 1'b0, ge, gs);
        check_output("raw_store_gnt", gs, 0);
        apply_stimulus(idle, mk(1, 0, 32'h420, 0, 0), 1'b0, ge, gs);
        check_output("raw_load_gnt", gs, 1);

        // Reset while a load response is pending and while a store is requested.
        apply_stimulus(mk(1, 0, 32'h20, 0, 0), idle, 1'b0, ge, gs);
        apply_stimulus(mk(1, 0, 32'h10, 0, 0), mk(1, 1, 32'h10, 32'hBAD0BAD0, 0), 1'b1, ge, gs);
        check_output("rst_no_gnt", gs, -1);
        apply_stimulus(mk(1, 0, 32'h10, 0, 0), mk(1, 0, 32'h20, 0, 0), 1'b0, ge, gs);
        check_output("post_rst_tie", gs, 0);
        apply_stimulus(idle, mk(1, 0, 32'h20, 0, 0), 1'b0, ge, gs);
        check_output("post_rst_p1", gs, 1);

        repeat (3) apply_stimulus(idle, idle, 1'b0, ge, gs);

        // Randomized traffic with held requests and random locks.
        pend[0] = idle;
        pend[1] = idle;
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].req && $urandom_range(0, 3) != 0) pend[p] = rand_req();
            end
            apply_stimulus(pend[0], pend[1], (i == 300), ge, gs);
            if (ge >= 0) pend[ge] = idle;
        end

        repeat (2) apply_stimulus(idle, idle, 1'b0, ge, gs);
        check_output("sb_drain_p0", sb[0].size(), 0);
        check_output("sb_drain_p1", sb[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
